// File: rtl/inst_fetch.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | inst_fetch : PC owner, ROM address driver and {pc, inst} fetch queue   |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module inst_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int            PW    = $clog2(QDEPTH);
  localparam logic [PW:0]   DEPTH = (PW+1)'(QDEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [31:0]   pc;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          pop;
  logic          push;

  assign inst_addr_o  = pc;
  assign inst_valid_o = (count != '0);
  assign inst_o       = q_inst[rd_ptr];
  assign inst_pc_o    = q_pc[rd_ptr];

  // A full queue still accepts a new fetch when the head leaves this cycle.
  assign pop  = inst_valid_o & inst_ready_i;
  assign push = ~jump_en_i & ((count < DEPTH) | pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= RESET_ADDR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (jump_en_i) begin
      // Wrong-path entries are dropped; a head shown this cycle is not consumed.
      pc     <= {jump_addr_i[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]   <= pc;
        q_inst[wr_ptr] <= inst_i;
        wr_ptr         <= wr_ptr + PTR_ONE;
        pc             <= pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// Bench for inst_fetch: directed vector table, hand corner sequences, and
// random traffic checked against a queue-based reference model.
module tb_inst_fetch;

  localparam int          QD    = 2;
  localparam logic [31:0] RADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign inst = rom(inst_addr);

  inst_fetch #(.RESET_ADDR(RADDR), .QDEPTH(QD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .inst_addr_o  (inst_addr),
    .inst_i       (inst),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .inst_o       (inst_out),
    .inst_pc_o    (inst_pc)
  );

  // Reference model: an ordered list of fetched {pc, inst} pairs plus the PC.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } entry_t;
  entry_t      q_m[$];
  logic [31:0] pc_m;

  task automatic model_step(input logic r, input logic j, input logic [31:0] ja, input logic rd);
    bit room;
    bit take;
    entry_t e;
    if (!r) begin
      q_m.delete();
      pc_m = RADDR;
    end else if (j) begin
      q_m.delete();
      pc_m = ja & 32'hFFFF_FFFC;
    end else begin
      room = (q_m.size() < QD);
      take = (q_m.size() != 0) && rd;
      if (take) e = q_m.pop_front();
      if (room || take) begin
        e.pc  = pc_m;
        e.ins = rom(pc_m);
        q_m.push_back(e);
        pc_m = pc_m + 32'd4;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply inputs for one clock, advance the model, then sample 1 time unit after the edge.
  task automatic cycle(input logic r, input logic j, input logic [31:0] ja, input logic rd);
    rst_n      = r;
    jump_en    = j;
    jump_addr  = ja;
    inst_ready = rd;
    @(posedge clk);
    model_step(r, j, ja, rd);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " addr"}, inst_addr, pc_m);
    check({tag, " valid"}, {31'd0, inst_valid}, {31'd0, q_m.size() != 0});
    if (q_m.size() != 0 && inst_valid) begin
      check({tag, " head_pc"}, inst_pc, q_m[0].pc);
      check({tag, " head_inst"}, inst_out, q_m[0].ins);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        jump;
    logic [31:0] jaddr;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic j, input logic [31:0] ja, input logic rd,
                     input logic ev, input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst_n = r; v.jump = j; v.jaddr = ja; v.ready = rd;
    v.exp_valid = ev; v.exp_addr = ea; v.exp_pc = ep; v.exp_inst = ei;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; jump_en = 1'b0; jump_addr = '0; inst_ready = 1'b0;
    pc_m = RADDR;

    // Free run from reset
    add(1,0,0,1, 1, 32'h4,  32'h0, 32'h1000_0000);
    add(1,0,0,1, 1, 32'h8,  32'h4, 32'h1000_0001);
    add(1,0,0,1, 1, 32'hC,  32'h8, 32'h1000_0002);
    // Reset, then stall with ready low
    add(0,0,0,1, 0, 32'h0,  32'h0, 32'h0);
    add(1,0,0,0, 1, 32'h4,  32'h0, 32'h1000_0000);
    for (int k = 0; k < 4; k++) add(1,0,0,0, 1, 32'h8, 32'h0, 32'h1000_0000);
    add(1,0,0,1, 1, 32'hC,  32'h4, 32'h1000_0001);
    add(1,0,0,1, 1, 32'h10, 32'h8, 32'h1000_0002);
    add(1,0,0,1, 1, 32'h14, 32'hC, 32'h1000_0003);
    add(1,0,0,0, 1, 32'h14, 32'hC, 32'h1000_0003);
    // Redirect while full, unaligned target
    add(1,1,32'h0000_0103,1, 0, 32'h100, 32'h0, 32'h0);
    add(1,0,0,0, 1, 32'h104, 32'h100, 32'h1000_0040);
    add(1,0,0,0, 1, 32'h108, 32'h100, 32'h1000_0040);
    // Full queue with simultaneous pop and push
    for (int k = 1; k <= 10; k++)
      add(1,0,0,1, 1, 32'h108 + 4*k, 32'h100 + 4*k, 32'h1000_0040 + k);
    // Address wrap
    add(1,1,32'hFFFF_FFF8,1, 0, 32'hFFFF_FFF8, 32'h0, 32'h0);
    add(1,0,0,1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h4FFF_FFFE);
    add(1,0,0,1, 1, 32'h0,         32'hFFFF_FFFC, 32'h4FFF_FFFF);
    add(1,0,0,1, 1, 32'h4,         32'h0,         32'h1000_0000);
    // Back-to-back redirects: last wins
    add(1,1,32'h200,1, 0, 32'h200, 32'h0, 32'h0);
    add(1,1,32'h302,0, 0, 32'h300, 32'h0, 32'h0);
    add(1,0,0,1, 1, 32'h304, 32'h300, 32'h1000_00C0);

    // Reset state, including zeroed storage
    cycle(0,0,0,1);
    cycle(0,0,0,1);
    check("reset valid", {31'd0, inst_valid}, 32'd0);
    check("reset addr", inst_addr, RADDR);
    check("reset inst", inst_out, 32'h0);
    check("reset pc", inst_pc, 32'h0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst_n, vecs[i].jump, vecs[i].jaddr, vecs[i].ready);
      check($sformatf("vec%0d addr", i), inst_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d head_pc", i), inst_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d head_inst", i), inst_out, vecs[i].exp_inst);
      end
    end

    // Reset together with a jump while the queue is full
    cycle(1,0,0,0);
    check_model("prefill");
    cycle(0,1,32'h500,1);
    check("rstjump valid", {31'd0, inst_valid}, 32'd0);
    check("rstjump addr", inst_addr, RADDR);
    check("rstjump inst", inst_out, 32'h0);
    check("rstjump pc", inst_pc, 32'h0);
    cycle(1,0,0,1);
    check("rstjump head_pc", inst_pc, RADDR);
    check("rstjump head_inst", inst_out, rom(RADDR));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        r, j, rd;
      logic [31:0] ja;
      r  = ($urandom_range(63) != 0);
      j  = ($urandom_range(11) == 0);
      rd = $urandom_range(1);
      ja = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      cycle(r, j, ja, rd);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
